// File: rtl/alu.sv
// Two-operand 32-bit ALU (ADD/SUB/AND/OR) for the MIPS execute stage.
// Result and status flags are registered, so they appear one cycle after capture.
module alu (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [1:0]  s,
  output logic [31:0] out,
  output logic        zero,
  output logic        neg,
  output logic        carry,
  output logic        ovf,
  output logic        valid
);

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_AND = 2'd2,
    OP_OR  = 2'd3
  } op_e;

  logic [32:0] add_w;
  logic [32:0] sub_w;
  logic [31:0] res;
  logic        res_c;
  logic        res_v;

  // Bit 32 of the zero-extended difference is the borrow: set exactly when a < b unsigned.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    add_w = {1'b0, a} + {1'b0, b};
    sub_w = {1'b0, a} - {1'b0, b};
    res   = '0;
    res_c = 1'b0;
    res_v = 1'b0;
    unique case (op_e'(s))
      OP_ADD: begin
        res   = add_w[31:0];
        res_c = add_w[32];
        res_v = (a[31] == b[31]) && (add_w[31] != a[31]);
      end
      OP_SUB: begin
        res   = sub_w[31:0];
        res_c = sub_w[32];
        res_v = (a[31] != b[31]) && (sub_w[31] != a[31]);
      end
      OP_AND: res = a & b;
      OP_OR:  res = a | b;
    endcase
  end

  // Reset outranks enable; with en low the result and flags hold but valid drops.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) begin
      out   <= '0;
      zero  <= 1'b1;
      neg   <= 1'b0;
      carry <= 1'b0;
      ovf   <= 1'b0;
      valid <= 1'b0;
    end else begin
      valid <= en;
      if (en) begin
        out   <= res;
        zero  <= (res == 32'd0);
        neg   <= res[31];
        carry <= res_c;
        ovf   <= res_v;
      end
    end
  end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vector table, hand sequences for reset/hold,
// and randomized traffic compared against an arithmetic reference model.
module tb_alu;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [31:0] a;
  logic [31:0] b;
  logic [1:0]  s;
  logic [31:0] out;
  logic        zero, neg, carry, ovf, valid;

  int errors = 0;
  int checks = 0;

  alu dut (
    .clk(clk), .rst(rst), .en(en), .a(a), .b(b), .s(s),
    .out(out), .zero(zero), .neg(neg), .carry(carry), .ovf(ovf), .valid(valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] out;
    logic        zero;
    logic        neg;
    logic        carry;
    logic        ovf;
    logic        valid;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  s;
    logic [31:0] out;
    logic        zero;
    logic        neg;
    logic        carry;
    logic        ovf;
  } vec_t;

  localparam exp_t RESET_EXP = '{out: 32'd0, zero: 1'b1, neg: 1'b0, carry: 1'b0, ovf: 1'b0, valid: 1'b0};

  // Reference model computed from wide integer arithmetic, not from bit-level rules.
  function automatic exp_t model_op(input logic [31:0] av, input logic [31:0] bv, input logic [1:0] sv);
    exp_t r;
    longint ua, ub, sa, sb, ures, sres;
    ua = longint'(av);
    ub = longint'(bv);
    sa = longint'($signed(av));
    sb = longint'($signed(bv));
    r.carry = 1'b0;
    r.ovf   = 1'b0;
    case (sv)
      2'd0: begin
        ures = ua + ub;
        sres = sa + sb;
        r.out   = ures[31:0];
        r.carry = (ures >= 64'sh1_0000_0000);
        r.ovf   = (sres > 64'sh7FFF_FFFF) || (sres < -64'sh8000_0000);
      end
      2'd1: begin
        ures = ua - ub;
        sres = sa - sb;
        r.out   = ures[31:0];
        r.carry = (ua < ub);
        r.ovf   = (sres > 64'sh7FFF_FFFF) || (sres < -64'sh8000_0000);
      end
      2'd2: r.out = av & bv;
      default: r.out = av | bv;
    endcase
    r.zero  = (r.out == 32'd0);
    r.neg   = (r.out >= 32'h8000_0000);
    r.valid = 1'b1;
    return r;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, req);
    end
  endtask

  // Drive one cycle of inputs, let the edge happen, then compare all outputs.
  task automatic cycle(input logic r, input logic e, input logic [31:0] av, input logic [31:0] bv,
                       input logic [1:0] sv, input exp_t ex, input string nm);
    rst = r; en = e; a = av; b = bv; s = sv;
    @(posedge clk);
    #1;
    check({nm, ".out"},   out,          ex.out);
    check({nm, ".zero"},  32'(zero),    32'(ex.zero));
    check({nm, ".neg"},   32'(neg),     32'(ex.neg));
    check({nm, ".carry"}, 32'(carry),   32'(ex.carry));
    check({nm, ".ovf"},   32'(ovf),     32'(ex.ovf));
    check({nm, ".valid"}, 32'(valid),   32'(ex.valid));
  endtask

  vec_t vecs[12];
  exp_t ex, held;

  initial begin
    vecs[0]  = '{32'd3000,       32'd2222,       2'd0, 32'd5222,       1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{32'd3000,       32'd2222,       2'd1, 32'd778,        1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{32'd3000,       32'd2222,       2'd2, 32'd2216,       1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{32'd3000,       32'd2222,       2'd3, 32'd3006,       1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{32'h7FFF_FFFF,  32'd1,          2'd0, 32'h8000_0000,  1'b0, 1'b1, 1'b0, 1'b1};
    vecs[5]  = '{32'hFFFF_FFFF,  32'd1,          2'd0, 32'h0000_0000,  1'b1, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{32'd0,          32'd1,          2'd1, 32'hFFFF_FFFF,  1'b0, 1'b1, 1'b1, 1'b0};
    vecs[7]  = '{32'h8000_0000,  32'd1,          2'd1, 32'h7FFF_FFFF,  1'b0, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{32'd5,          32'd5,          2'd1, 32'h0000_0000,  1'b1, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{32'hF0F0_F0F0,  32'h0F0F_0F0F,  2'd2, 32'h0000_0000,  1'b1, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{32'hF0F0_F0F0,  32'h0F0F_0F0F,  2'd3, 32'hFFFF_FFFF,  1'b0, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{32'h8000_0000,  32'h8000_0000,  2'd0, 32'h0000_0000,  1'b1, 1'b0, 1'b1, 1'b1};

    rst = 1'b1; en = 1'b0; a = '0; b = '0; s = '0;

    // Reset held two cycles with en low.
    cycle(1'b1, 1'b0, 32'd0, 32'd0, 2'd0, RESET_EXP, "rst0");
    cycle(1'b1, 1'b0, 32'd0, 32'd0, 2'd0, RESET_EXP, "rst1");

    // Capture something nonzero, then reset with en held high: reset must win.
    cycle(1'b0, 1'b1, 32'd3000, 32'd2222, 2'd0, model_op(32'd3000, 32'd2222, 2'd0), "pre_rst");
    cycle(1'b1, 1'b1, 32'h7FFF_FFFF, 32'd1, 2'd0, RESET_EXP, "rst_en0");
    cycle(1'b1, 1'b1, 32'h1234_5678, 32'd9, 2'd3, RESET_EXP, "rst_en1");

    // Directed table, back-to-back captures.
    for (int i = 0; i < 12; i++) begin
      ex = '{out: vecs[i].out, zero: vecs[i].zero, neg: vecs[i].neg,
             carry: vecs[i].carry, ovf: vecs[i].ovf, valid: 1'b1};
      cycle(1'b0, 1'b1, vecs[i].a, vecs[i].b, vecs[i].s, ex, $sformatf("vec%0d", i));
    end

    // Hold: capture a flagged result, then three cycles of en low with changing inputs.
    held = '{out: 32'h8000_0000, zero: 1'b0, neg: 1'b1, carry: 1'b0, ovf: 1'b1, valid: 1'b1};
    cycle(1'b0, 1'b1, 32'h7FFF_FFFF, 32'd1, 2'd0, held, "hold_cap");
    held.valid = 1'b0;
    cycle(1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 2'd0, held, "hold0");
    cycle(1'b0, 1'b0, 32'd5, 32'd5, 2'd1, held, "hold1");
    cycle(1'b0, 1'b0, 32'd0, 32'd0, 2'd3, held, "hold2");

    // Randomized traffic with sporadic enable drops and resets.
    for (int i = 0; i < 300; i++) begin
      logic        r, e;
      logic [31:0] av, bv;
      logic [1:0]  sv;
      r  = ($urandom_range(0, 31) == 0);
      e  = ($urandom_range(0, 3) != 0);
      sv = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0:       av = 32'h8000_0000 - 32'($urandom_range(0, 2));
        1:       av = 32'($urandom_range(0, 3));
        default: av = $urandom;
      endcase
      case ($urandom_range(0, 3))
        0:       bv = av;
        1:       bv = 32'hFFFF_FFFF - 32'($urandom_range(0, 2));
        default: bv = $urandom;
      endcase
      if (r)      held = RESET_EXP;
      else if (e) held = model_op(av, bv, sv);
      else        held.valid = 1'b0;
      cycle(r, e, av, bv, sv, held, $sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
